rv_dmem_wait: RTL and testbench

- Parametrised data-memory model for the multicycle RISC-V core.
- Adds a request/ready handshake with a configurable number of wait states, per-byte write enables and out-of-range error reporting.
- Detects the program-completion write in hardware and raises a sticky done flag, with a run-cycle counter.
- Sits between the core's data-memory port and the simulation top level. It replaces the bare always-ready word-only array.

---
 rtl/rv_dmem_wait.sv | 134 +++++++++++++
 tb/tb_rv_dmem_wait.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_dmem_wait.sv
// Data-memory model with request/ready handshake, configurable wait states,
// byte enables, out-of-range error reporting and completion-write detection.
module rv_dmem_wait #(
    parameter int                 DPWIDTH      = 32,
    parameter int                 LOGDMEM_SIZE = 10,
    parameter int                 WAIT_STATES  = 2,
    parameter logic [DPWIDTH-1:0] DONE_ADDR    = 32'h0000FFFF,
    parameter logic [31:0]        DONE_DATA    = 32'h0000DEAD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               we,
    input  logic [DPWIDTH-1:0] addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         be,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               err,
    output logic               done,
    output logic [31:0]        cycles
);

    localparam int DEPTH = 2 ** LOGDMEM_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [LOGDMEM_SIZE-1:0] idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    errPend_q, errPend_d;
    logic [31:0]             cycles_q;

    logic [31:0] mem [0:DEPTH-1];

    logic addrErr;
    logic isDone;

    // Misaligned addresses and any address beyond the array are rejected.
    assign addrErr = (addr[1:0] != 2'b00) || ((addr >> (LOGDMEM_SIZE + 2)) != '0);
    assign isDone  = we && (addr == DONE_ADDR) && (wdata == DONE_DATA);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        errPend_d = errPend_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d      = we;
                    idx_d     = addr[LOGDMEM_SIZE+1:2];
                    wdata_d   = wdata;
                    be_d      = be;
                    errPend_d = 1'b0;
                    if (isDone) begin
                        state_d = S_DONE;
                    end else if (addrErr) begin
                        errPend_d = 1'b1;
                        state_d   = S_RESP;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            errPend_q <= 1'b0;
            cycles_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            errPend_q <= errPend_d;
            if (state_q != S_DONE) begin
                cycles_q <= cycles_q + 32'd1;
            end
        end
    end

    // Storage is deliberately left out of reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !errPend_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ready  = (state_q == S_RESP);
    assign err    = ready && errPend_q;
    assign rdata  = (ready && !we_q && !errPend_q) ? mem[idx_q] : 32'd0;
    assign done   = (state_q == S_DONE);
    assign cycles = cycles_q;

endmodule

// File: tb/tb_rv_dmem_wait.sv
// Self-checking bench for rv_dmem_wait: a WAIT_STATES=2 and a WAIT_STATES=0
// instance are compared against a word-array reference model.
module tb_rv_dmem_wait;

    logic        clk;
    logic        rst;
    logic        req2, req0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0;
    logic        err2, err0;
    logic        done2, done0;
    logic [31:0] cycles2, cycles0;

    int total = 0;
    int bad   = 0;
    int refCyc = 0;
    bit refDone = 1'b0;

    logic [31:0] m2 [0:1023];
    logic [31:0] m0 [0:1023];

    rv_dmem_wait #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata2), .ready(ready2), .err(err2), .done(done2), .cycles(cycles2)
    );

    rv_dmem_wait #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata0), .ready(ready0), .err(err0), .done(done0), .cycles(cycles0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycles elapsed since reset release, frozen once completion has been seen.
    always @(posedge clk) begin
        if (rst) refCyc = 0;
        else if (!refDone) refCyc = refCyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic doAccess(input bit sel, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b;
        if (sel) req2 = 1'b1; else req0 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0; req0 = 1'b0;
        lat = 0; rd = 32'd0; e = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sel ? ready2 : ready0) begin
                lat = i;
                rd  = sel ? rdata2 : rdata0;
                e   = sel ? err2 : err0;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b, input string tag);
        logic [31:0] rd, expRd, word;
        logic        e, expErr;
        int          lat, expLat;
        expErr = (a[1:0] != 2'b00) || ((a >> 12) != 0);
        expLat = expErr ? 1 : (sel ? 3 : 1);
        word   = sel ? m2[a[11:2]] : m0[a[11:2]];
        expRd  = (!w && !expErr) ? word : 32'd0;
        doAccess(sel, w, a, d, b, rd, e, lat);
        checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".err"}, {31'd0, e}, {31'd0, expErr});
        checkOutput({tag, ".rdata"}, rd, expRd);
        if (w && !expErr) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) word[8*i +: 8] = d[8*i +: 8];
            if (sel) m2[a[11:2]] = word; else m0[a[11:2]] = word;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check(tag, obs, exp);
    endtask

    initial begin
        logic [31:0] a, d, c0;
        int kind;
        rst = 1'b1; req2 = 1'b0; req0 = 1'b0;
        we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst.ready", {31'd0, ready2}, 32'd0);
        checkOutput("rst.err", {31'd0, err2}, 32'd0);
        checkOutput("rst.done", {31'd0, done2}, 32'd0);
        checkOutput("rst.rdata", rdata2, 32'd0);
        checkOutput("rst.cycles2", cycles2, 32'd0);
        checkOutput("rst.cycles0", cycles0, 32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, "pre2");
            applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "pre0");
        end

        applyStimulus(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, "tp1.wr");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "tp1.rd");
        checkOutput("tp1.model", m2[4], 32'hA5A5A5A5);

        applyStimulus(1'b1, 1'b1, 32'h10, 32'h11223344, 4'hF, "tp2.pre");
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0101, "tp2.wr");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "tp2.rd");
        checkOutput("tp2.model", m2[4], 32'h11FF33FF);

        applyStimulus(1'b1, 1'b0, 32'h12, 32'd0, 4'hF, "err.mis");
        applyStimulus(1'b1, 1'b0, 32'h1000, 32'd0, 4'hF, "err.oor");
        applyStimulus(1'b1, 1'b1, 32'h12, 32'hCAFEF00D, 4'hF, "err.wmis");
        applyStimulus(1'b1, 1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, "err.woor");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "err.keep");

        applyStimulus(1'b1, 1'b1, 32'h10, 32'h12345678, 4'h0, "be0.wr");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "be0.rd");
        applyStimulus(1'b1, 1'b1, 32'hFFFF, 32'h0000BEEF, 4'hF, "nearDone");
        checkOutput("nearDone.done", {31'd0, done2}, 32'd0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) * 4;
            if (kind == 8) a = a + 32'($urandom_range(1, 3));
            if (kind == 9) a = a | (32'h1000 << $urandom_range(0, 19));
            d = $urandom;
            applyStimulus(n[0], $urandom_range(0, 1) == 1, a, d, 4'($urandom_range(0, 15)), "rand");
        end

        // WAIT_STATES=0 back-to-back: req held high, address changed after acceptance.
        @(negedge clk);
        we = 1'b0; addr = 32'h0; be = 4'hF; req0 = 1'b1;
        @(posedge clk);
        #1 addr = 32'h4;
        @(negedge clk);
        checkOutput("b2b.ready1", {31'd0, ready0}, 32'd1);
        checkOutput("b2b.rdata1", rdata0, m0[0]);
        @(negedge clk);
        checkOutput("b2b.gap", {31'd0, ready0}, 32'd0);
        @(negedge clk);
        checkOutput("b2b.ready2", {31'd0, ready0}, 32'd1);
        checkOutput("b2b.rdata2", rdata0, m0[1]);
        req0 = 1'b0;
        @(negedge clk);

        checkOutput("cyc2", cycles2, 32'(refCyc));
        checkOutput("cyc0", cycles0, 32'(refCyc));

        // Reset during the wait states of a write to word 8.
        a = m2[8];
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = ~a; be = 4'hF; req2 = 1'b1;
        @(posedge clk);
        #1 req2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid.ready", {31'd0, ready2}, 32'd0);
        checkOutput("mid.cycles", cycles2, 32'd0);
        @(negedge clk);
        checkOutput("mid.ready2", {31'd0, ready2}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'd0, 4'hF, "mid.rd");
        checkOutput("mid.keep", m2[8], a);

        // Completion write: terminal state with frozen cycle count.
        @(negedge clk);
        we = 1'b1; addr = 32'hFFFF; wdata = 32'h0000DEAD; be = 4'hF; req2 = 1'b1;
        @(posedge clk);
        #1 we = 1'b0; addr = 32'h0;
        refDone = 1'b1;
        @(negedge clk);
        checkOutput("done.flag", {31'd0, done2}, 32'd1);
        checkOutput("done.ready", {31'd0, ready2}, 32'd0);
        checkOutput("done.cycles", cycles2, 32'(refCyc));
        c0 = cycles2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("done.hold", {31'd0, ready2}, 32'd0);
            checkOutput("done.freeze", cycles2, c0);
        end
        req2 = 1'b0;
        checkOutput("done.sticky", {31'd0, done2}, 32'd1);

        rst = 1'b1;
        refDone = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst2.done", {31'd0, done2}, 32'd0);
        checkOutput("rst2.cycles", cycles2, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "rst2.rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
